// File: rtl/pulp_cluster_launcher.sv
// Cluster launch sequencer: per-cluster ARM/RUN/DONE FSMs driving fetch enables, plus a
// round-robin completion channel reporting one finished cluster at a time.
module pulp_cluster_launcher #(
  parameter int unsigned N_CLUSTERS = 4,
  parameter int unsigned TO_W       = 16,
  localparam int unsigned CW        = (N_CLUSTERS > 1) ? $clog2(N_CLUSTERS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  launch_valid_i,
  output logic                  launch_ready_o,
  input  logic [N_CLUSTERS-1:0] launch_mask_i,
  input  logic [TO_W-1:0]       timeout_i,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output logic [CW-1:0]         done_cluster_o,
  output logic                  done_timeout_o,
  output logic [N_CLUSTERS-1:0] cl_fetch_en_o,
  input  logic [N_CLUSTERS-1:0] cl_eoc_i,
  input  logic [N_CLUSTERS-1:0] cl_busy_i,
  output logic [N_CLUSTERS-1:0] cl_idle_o,
  output logic                  irq_o
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

  state_e                state_q [N_CLUSTERS];
  state_e                state_d [N_CLUSTERS];
  logic [TO_W-1:0]       cnt_q   [N_CLUSTERS];
  logic [TO_W-1:0]       cnt_d   [N_CLUSTERS];
  logic [N_CLUSTERS-1:0] tflag_q, tflag_d;

  logic                  done_valid_q, done_valid_d;
  logic [CW-1:0]         done_cluster_q, done_cluster_d;
  logic                  done_timeout_q, done_timeout_d;
  logic [CW-1:0]         rr_q, rr_d;

  logic [N_CLUSTERS-1:0] idle, cand;
  logic                  launch_fire, done_hs, to_armed, found;
  logic [TO_W-1:0]       to_last;
  logic [31:0]           scan;
  logic [CW-1:0]         scan_idx;

  always_comb begin
    for (int i = 0; i < N_CLUSTERS; i++) begin
      idle[i]          = (state_q[i] == StIdle);
      cl_fetch_en_o[i] = (state_q[i] == StArm) || (state_q[i] == StRun);
      // The record currently held is not a candidate for reloading.
      cand[i]          = (state_q[i] == StDone) &&
                         !(done_valid_q && (done_cluster_q == CW'(i)));
    end
  end

  assign launch_ready_o = &(~launch_mask_i | idle);
  assign launch_fire    = launch_valid_i & launch_ready_o;
  assign done_hs        = done_valid_q & done_ready_i;
  assign to_armed       = (timeout_i != '0);
  assign to_last        = timeout_i - TO_W'(1);

  always_comb begin
    for (int i = 0; i < N_CLUSTERS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tflag_d[i] = tflag_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (launch_fire && launch_mask_i[i]) begin
            state_d[i] = StArm;
            cnt_d[i]   = '0;
            tflag_d[i] = 1'b0;
          end
        end
        StArm: begin
          cnt_d[i] = cnt_q[i] + TO_W'(1);
          if (to_armed && (cnt_q[i] == to_last)) begin
            state_d[i] = StDone;
            tflag_d[i] = 1'b1;
          end else if (!cl_eoc_i[i] || cl_busy_i[i]) begin
            state_d[i] = StRun;
          end
        end
        StRun: begin
          cnt_d[i] = cnt_q[i] + TO_W'(1);
          if (cl_eoc_i[i]) begin
            state_d[i] = StDone;
            tflag_d[i] = 1'b0;
          end else if (to_armed && (cnt_q[i] == to_last)) begin
            state_d[i] = StDone;
            tflag_d[i] = 1'b1;
          end
        end
        StDone: begin
          if (done_hs && (done_cluster_q == CW'(i))) begin
            state_d[i] = StIdle;
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_comb begin
    done_valid_d   = done_valid_q;
    done_cluster_d = done_cluster_q;
    done_timeout_d = done_timeout_q;
    rr_d           = rr_q;
    found          = 1'b0;
    scan           = '0;
    scan_idx       = '0;
    if (!done_valid_q || done_hs) begin
      done_valid_d = 1'b0;
      for (int unsigned j = 0; j < N_CLUSTERS; j++) begin
        scan     = (32'(rr_q) + j) % N_CLUSTERS;
        scan_idx = scan[CW-1:0];
        if (!found && cand[scan_idx]) begin
          found          = 1'b1;
          done_valid_d   = 1'b1;
          done_cluster_d = scan_idx;
          done_timeout_d = tflag_q[scan_idx];
          if (32'(scan_idx) == N_CLUSTERS - 1) begin
            rr_d = '0;
          end else begin
            rr_d = scan_idx + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CLUSTERS; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      tflag_q        <= '0;
      done_valid_q   <= 1'b0;
      done_cluster_q <= '0;
      done_timeout_q <= 1'b0;
      rr_q           <= '0;
    end else begin
      for (int i = 0; i < N_CLUSTERS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      tflag_q        <= tflag_d;
      done_valid_q   <= done_valid_d;
      done_cluster_q <= done_cluster_d;
      done_timeout_q <= done_timeout_d;
      rr_q           <= rr_d;
    end
  end

  assign cl_idle_o      = idle;
  assign done_valid_o   = done_valid_q;
  assign done_cluster_o = done_cluster_q;
  assign done_timeout_o = done_timeout_q;
  assign irq_o          = done_valid_q;

endmodule
